// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the cache hierarchy.
package lc3b_types;

    localparam int unsigned LC3B_LINE_W = 256;

    typedef logic [15:0]            lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

endpackage

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 port between the I-cache and
// D-cache miss paths. The grant is held until l2_resp, followed by one
// dead cycle before the next arbitration.
module l2_port_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [15:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [15:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [15:0]       l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,

    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    arb_state_t        state_q;
    gnt_t              last_q;
    gnt_t              winner_q;
    logic              rd_q;
    logic              wr_q;
    lc3b_word          addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CNT_W-1:0]  icnt_q;
    logic [CNT_W-1:0]  dcnt_q;

    logic              i_req;
    logic              d_req;
    gnt_t              grant_d;
    logic              done;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        grant_d = GNT_I;
        if (d_req && (!i_req || (last_q == GNT_I))) begin
            grant_d = GNT_D;
        end
    end

    // Arbiter FSM: grant and latch in IDLE, hold through BUSY, one dead GAP cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= GNT_I;
            winner_q <= GNT_I;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            icnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        winner_q <= grant_d;
                        state_q  <= BUSY;
                        if (grant_d == GNT_D) begin
                            addr_q  <= d_address;
                            // d_write wins over a simultaneous d_read
                            rd_q    <= ~d_write;
                            wr_q    <= d_write;
                            wdata_q <= d_write ? d_wdata : '0;
                        end else begin
                            addr_q  <= i_address;
                            rd_q    <= 1'b1;
                            wr_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (l2_resp) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        last_q  <= winner_q;
                        state_q <= GAP;
                        if (winner_q == GNT_I) begin
                            if (icnt_q != '1) icnt_q <= icnt_q + 1'b1;
                        end else begin
                            if (dcnt_q != '1) dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response routing: only the current winner sees l2_resp and l2_rdata.
    always_comb begin
        done    = (state_q == BUSY) && l2_resp;
        i_resp  = done && (winner_q == GNT_I);
        d_resp  = done && (winner_q == GNT_D);
        i_rdata = i_resp ? l2_rdata : '0;
        d_rdata = d_resp ? l2_rdata : '0;
    end

    assign l2_read     = rd_q;
    assign l2_write    = wr_q;
    assign l2_address  = addr_q;
    assign l2_wdata    = wdata_q;
    assign i_grant_cnt = icnt_q;
    assign d_grant_cnt = dcnt_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: a cycle table plus directed sequences.
module tb_l2_port_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = 16;
    localparam logic [LINE_W-1:0] RDAT = {8{32'hA5C3_0F1E}};
    localparam logic [LINE_W-1:0] WDAT = {8{32'h1234_5678}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read;
    logic [15:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [15:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [15:0]       l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic [CNT_W-1:0]  i_grant_cnt;
    logic [CNT_W-1:0]  d_grant_cnt;

    int passed = 0;
    int total  = 0;

    l2_port_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, dw, rsp;
        logic        e_rd, e_wr, e_iresp, e_dresp;
        logic [15:0] e_addr;
        logic [15:0] e_icnt, e_dcnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        chk("rst_cnt", {i_grant_cnt, d_grant_cnt}, 0);
        rst_n = 1'b1;
    endtask

    // Wait at negedges until a request appears on the L2 port, bounded.
    task automatic wait_busy(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            l2_resp = 1'b0;
            #1;
            if (l2_read || l2_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        i_address = 16'h0020;
        d_address = 16'h3FE0;
        d_wdata   = WDAT;
        l2_rdata  = RDAT;

        //         ir dr dw rsp rd wr ir dr addr      icnt dcnt
        vecs[0] = '{1, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0};
        vecs[1] = '{1, 0, 1, 0, 0, 1, 0, 0, 16'h3FE0, 0, 0};
        vecs[2] = '{1, 0, 1, 1, 0, 1, 0, 1, 16'h3FE0, 0, 0};
        vecs[3] = '{1, 0, 0, 0, 0, 0, 0, 0, 16'h3FE0, 0, 1};
        vecs[4] = '{1, 0, 0, 0, 0, 0, 0, 0, 16'h3FE0, 0, 1};
        vecs[5] = '{1, 0, 0, 0, 1, 0, 0, 0, 16'h0020, 0, 1};
        vecs[6] = '{1, 0, 0, 1, 1, 0, 1, 0, 16'h0020, 0, 1};
        vecs[7] = '{0, 0, 0, 1, 0, 0, 0, 0, 16'h0020, 1, 1};
        vecs[8] = '{0, 0, 0, 1, 0, 0, 0, 0, 16'h0020, 1, 1};

        // Simultaneous I read and D write after reset: D first, then I after GAP
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            i_read  = vecs[k].ir;
            d_read  = vecs[k].dr;
            d_write = vecs[k].dw;
            l2_resp = vecs[k].rsp;
            #1;
            chk($sformatf("v%0d_l2_read", k), l2_read, vecs[k].e_rd);
            chk($sformatf("v%0d_l2_write", k), l2_write, vecs[k].e_wr);
            chk($sformatf("v%0d_i_resp", k), i_resp, vecs[k].e_iresp);
            chk($sformatf("v%0d_d_resp", k), d_resp, vecs[k].e_dresp);
            chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].e_iresp ? RDAT : '0);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].e_dresp ? RDAT : '0);
            chk($sformatf("v%0d_i_cnt", k), i_grant_cnt, vecs[k].e_icnt);
            chk($sformatf("v%0d_d_cnt", k), d_grant_cnt, vecs[k].e_dcnt);
            if (vecs[k].e_rd || vecs[k].e_wr)
                chk($sformatf("v%0d_addr", k), l2_address, vecs[k].e_addr);
            if (vecs[k].e_wr)
                chk($sformatf("v%0d_wdata", k), l2_wdata, WDAT);
        end

        // I-only read of 0x1240, L2 answers three cycles after l2_read
        do_reset();
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h1240;
        @(negedge clk); #1;
        chk("t1_l2_read", l2_read, 1);
        chk("t1_addr", l2_address, 16'h1240);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("t1_hold_read", l2_read, 1);
            chk("t1_no_resp", {i_resp, d_resp}, 0);
        end
        @(negedge clk);
        l2_resp = 1'b1; #1;
        chk("t1_i_resp", i_resp, 1);
        chk("t1_i_rdata", i_rdata, RDAT);
        chk("t1_d_resp", d_resp, 0);
        chk("t1_d_rdata", d_rdata, 0);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b0; #1;
        chk("t1_resp_pulse", i_resp, 0);
        chk("t1_l2_read_off", l2_read, 0);
        chk("t1_i_cnt", i_grant_cnt, 1);

        // Both requests held: grants alternate D,I,D,I,D,I
        do_reset();
        @(negedge clk);
        i_read = 1'b1; d_read = 1'b1; i_address = 16'h0040; d_address = 16'h0080;
        for (int t = 0; t < 6; t++) begin
            wait_busy($sformatf("t3_wait%0d", t));
            chk($sformatf("t3_addr%0d", t), l2_address, (t % 2 == 0) ? 16'h0080 : 16'h0040);
            chk($sformatf("t3_rd%0d", t), {l2_read, l2_write}, 2'b10);
            l2_resp = 1'b1; #1;
            chk($sformatf("t3_winner%0d", t), {i_resp, d_resp},
                (t % 2 == 0) ? 2'b01 : 2'b10);
        end
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; #1;
        chk("t3_i_cnt", i_grant_cnt, 3);
        chk("t3_d_cnt", d_grant_cnt, 3);

        // d_read drops mid-BUSY; GAP then IDLE must pass before the next grant
        do_reset();
        @(negedge clk);
        d_read = 1'b1; d_address = 16'h0100;
        @(negedge clk); #1;
        chk("t4_read", l2_read, 1);
        d_read = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("t4_read_held", l2_read, 1);
        end
        l2_resp = 1'b1; #1;
        chk("t4_d_resp", d_resp, 1);
        chk("t4_d_rdata", d_rdata, RDAT);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b1; i_address = 16'h0200; #1;
        chk("t4_gap_idle", l2_read, 0);
        @(negedge clk); #1;
        chk("t4_idle_no_req", l2_read, 0);
        @(negedge clk); #1;
        chk("t4_regrant", l2_read, 1);
        chk("t4_regrant_addr", l2_address, 16'h0200);
        l2_resp = 1'b1;
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b0;

        // Reset while BUSY abandons the transaction; stray l2_resp afterwards is ignored
        do_reset();
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h0300;
        wait_busy("t5_wait_a");
        l2_resp = 1'b1;
        wait_busy("t5_wait_b");
        chk("t5_i_cnt_pre", i_grant_cnt, 1);
        rst_n = 1'b0; i_read = 1'b0;
        @(negedge clk); #1;
        chk("t5_read_off", l2_read, 0);
        chk("t5_write_off", l2_write, 0);
        chk("t5_cnt_clear", {i_grant_cnt, d_grant_cnt}, 0);
        rst_n = 1'b1;
        l2_resp = 1'b1; #1;
        chk("t5_stray_a", {i_resp, d_resp}, 0);
        @(negedge clk); #1;
        chk("t5_stray_b", {i_resp, d_resp}, 0);
        chk("t5_stray_rdata", i_rdata | d_rdata, 0);
        l2_resp = 1'b0;

        // Counter saturation at all-ones
        do_reset();
        @(negedge clk);
        force dut.icnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.icnt_q;
        #1;
        chk("t6_preload", i_grant_cnt, 16'hFFFF);
        i_read = 1'b1; i_address = 16'h0400;
        wait_busy("t6_wait");
        l2_resp = 1'b1; #1;
        chk("t6_i_resp", i_resp, 1);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b0; #1;
        chk("t6_saturate", i_grant_cnt, 16'hFFFF);
        chk("t6_d_cnt", d_grant_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
